// File: rtl/slc3_mem_responder.sv
// SLC-3 memory-side responder: zero-filled on-chip word RAM with fixed read latency,
// plus the memory-mapped switch/hex word at IO_ADDR.
module slc3_mem_responder #(
   parameter int unsigned ADDR_BITS    = 10,
   parameter int unsigned READ_LATENCY = 2,
   parameter logic [15:0] IO_ADDR      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_mem_ena,
   input  logic        mem_wr_ena,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        rd_valid_o,
   input  logic [15:0] sw_i,
   output logic [15:0] hex_o,
   output logic        init_done_o
);

   localparam int unsigned          DEPTH     = 1 << ADDR_BITS;
   localparam logic [16:0]          DEPTH_EXT = 17'(DEPTH);
   localparam logic [ADDR_BITS-1:0] LAST_IDX  = '1;

   typedef enum logic {S_INIT, S_RUN} state_t;
   typedef enum logic [1:0] {SRC_RAM, SRC_IO, SRC_ZERO} src_t;

   // Out-of-range reads travel down the pipe like any other and are zeroed at the end.
   function automatic logic [15:0] resolve_rdata(input src_t src, input logic [15:0] dat);
      if (src == SRC_ZERO) begin
         return 16'h0000;
      end
      return dat;
   endfunction

   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
   logic [15:0]            hex_q, hex_d;

   logic                   is_io;
   logic                   in_range;
   src_t                   src_d;
   logic                   rd_req;
   logic                   ram_we;
   logic [ADDR_BITS-1:0]   ram_idx;
   logic [15:0]            ram_wdata;

   logic [15:0]            ram_q [0:DEPTH-1];
   logic [15:0]            ram_dout_p0_q;
   logic                   vld_p0_q;
   src_t                   src_p0_q;
   logic [15:0]            sw_p0_q;
   logic [15:0]            dat_p0;

   logic                   vld_tail;
   src_t                   src_tail;
   logic [15:0]            dat_tail;
   logic [15:0]            rdata_q;
   logic                   rd_valid_q;

   assign is_io    = (mem_addr == IO_ADDR);
   assign in_range = ({1'b0, mem_addr} < DEPTH_EXT);
   assign src_d    = is_io ? SRC_IO : (in_range ? SRC_RAM : SRC_ZERO);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hex_d     = hex_q;
      rd_req    = 1'b0;
      ram_we    = 1'b0;
      ram_idx   = mem_addr[ADDR_BITS-1:0];
      ram_wdata = mem_wdata;
      case (state_q)
         S_INIT: begin
            ram_we    = 1'b1;
            ram_idx   = cnt_q;
            ram_wdata = 16'h0000;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (mem_mem_ena) begin
               if (mem_wr_ena) begin
                  if (is_io) begin
                     hex_d = mem_wdata;
                  end else if (in_range) begin
                     ram_we = 1'b1;
                  end
               end else begin
                  rd_req = 1'b1;
               end
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_INIT;
         cnt_q    <= '0;
         hex_q    <= 16'h0000;
         vld_p0_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hex_q    <= hex_d;
         vld_p0_q <= rd_req;
      end
   end

   // Stage p0: single-port read-first RAM, so a read right after a write sees the new word.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= ram_wdata;
      end
      ram_dout_p0_q <= ram_q[ram_idx];
      src_p0_q      <= src_d;
      sw_p0_q       <= sw_i;
   end

   assign dat_p0 = (src_p0_q == SRC_IO) ? sw_p0_q : ram_dout_p0_q;

   generate
      if (READ_LATENCY <= 1) begin : g_direct
         assign vld_tail = vld_p0_q;
         assign src_tail = src_p0_q;
         assign dat_tail = dat_p0;
      end else begin : g_shift
         localparam int unsigned N = READ_LATENCY - 1;
         logic        vld_q [N];
         src_t        src_q [N];
         logic [15:0] dat_q [N];

         // Stages p1..pN: only valid is reset, so a reset flushes in-flight reads.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < N; i++) begin
                  vld_q[i] <= 1'b0;
               end
            end else begin
               vld_q[0] <= vld_p0_q;
               for (int i = 1; i < N; i++) begin
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            src_q[0] <= src_p0_q;
            dat_q[0] <= dat_p0;
            for (int i = 1; i < N; i++) begin
               src_q[i] <= src_q[i-1];
               dat_q[i] <= dat_q[i-1];
            end
         end

         assign vld_tail = vld_q[N-1];
         assign src_tail = src_q[N-1];
         assign dat_tail = dat_q[N-1];
      end
   endgenerate

   // Output stage: mem_rdata holds between results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q    <= 16'h0000;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= vld_tail;
         if (vld_tail) begin
            rdata_q <= resolve_rdata(src_tail, dat_tail);
         end
      end
   end

   assign mem_rdata   = rdata_q;
   assign rd_valid_o  = rd_valid_q;
   assign hex_o       = hex_q;
   assign init_done_o = (state_q == S_RUN);

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: three latencies driven in lockstep against an
// issue-time behavioural model, plus directed literal checks.
module tb_slc3_mem_responder;

   localparam int          AB    = 10;
   localparam int          DEPTH = 1 << AB;
   localparam logic [15:0] IO    = 16'hFFFF;
   localparam int          NL    = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_mem_ena = 1'b0;
   logic        mem_wr_ena = 1'b0;
   logic [15:0] mem_addr = 16'h0;
   logic [15:0] mem_wdata = 16'h0;
   logic [15:0] sw_i = 16'h0;

   logic [15:0] rdata_w [NL];
   logic        rdv_w   [NL];
   logic [15:0] hex_w   [NL];
   logic        init_w  [NL];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   slc3_mem_responder #(.ADDR_BITS(AB), .READ_LATENCY(1), .IO_ADDR(IO)) u_l1 (
      .clk(clk), .reset(reset), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata_w[0]), .rd_valid_o(rdv_w[0]),
      .sw_i(sw_i), .hex_o(hex_w[0]), .init_done_o(init_w[0]));

   slc3_mem_responder #(.ADDR_BITS(AB), .READ_LATENCY(2), .IO_ADDR(IO)) u_l2 (
      .clk(clk), .reset(reset), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata_w[1]), .rd_valid_o(rdv_w[1]),
      .sw_i(sw_i), .hex_o(hex_w[1]), .init_done_o(init_w[1]));

   slc3_mem_responder #(.ADDR_BITS(AB), .READ_LATENCY(4), .IO_ADDR(IO)) u_l4 (
      .clk(clk), .reset(reset), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata_w[2]), .rd_valid_o(rdv_w[2]),
      .sw_i(sw_i), .hex_o(hex_w[2]), .init_done_o(init_w[2]));

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check32(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: memory after init is all zero; each read's result is fixed at issue time
   // and appears L edges later; requests during the first DEPTH edges are ignored.
   logic [15:0] m_mem [DEPTH];
   logic [15:0] m_hex;
   int          m_edges;
   logic        hv [5];
   logic [15:0] hd [5];
   logic [15:0] m_rdata [NL];

   always @(posedge clk or posedge reset) begin : model
      logic        iss;
      logic [15:0] dat;
      if (reset) begin
         for (int j = 0; j < DEPTH; j++) m_mem[j] = 16'h0;
         m_hex   = 16'h0;
         m_edges = 0;
         for (int j = 0; j < 5; j++) begin
            hv[j] = 1'b0;
            hd[j] = 16'h0;
         end
         for (int i = 0; i < NL; i++) m_rdata[i] = 16'h0;
      end else begin
         iss = 1'b0;
         dat = 16'h0;
         if (m_edges < DEPTH) begin
            m_edges++;
         end else if (mem_mem_ena) begin
            if (mem_wr_ena) begin
               if (mem_addr == IO) m_hex = mem_wdata;
               else if (int'(mem_addr) < DEPTH) m_mem[mem_addr[AB-1:0]] = mem_wdata;
            end else begin
               iss = 1'b1;
               if (mem_addr == IO) dat = sw_i;
               else if (int'(mem_addr) < DEPTH) dat = m_mem[mem_addr[AB-1:0]];
               else dat = 16'h0;
            end
         end
         for (int j = 4; j > 0; j--) begin
            hv[j] = hv[j-1];
            hd[j] = hd[j-1];
         end
         hv[0] = iss;
         hd[0] = dat;
         for (int i = 0; i < NL; i++) begin
            if (hv[lat_of(i)]) m_rdata[i] = hd[lat_of(i)];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NL; i++) begin
         check16($sformatf("rdata_L%0d", lat_of(i)), rdata_w[i], m_rdata[i]);
         check16($sformatf("rd_valid_L%0d", lat_of(i)), {15'b0, rdv_w[i]}, {15'b0, hv[lat_of(i)]});
         check16($sformatf("hex_L%0d", lat_of(i)), hex_w[i], m_hex);
         check16($sformatf("init_done_L%0d", lat_of(i)), {15'b0, init_w[i]},
                 {15'b0, (m_edges >= DEPTH)});
      end
   end

   task automatic cyc(input logic ena, input logic wr, input logic [15:0] a, input logic [15:0] d);
      mem_mem_ena = ena;
      mem_wr_ena  = wr;
      mem_addr    = a;
      mem_wdata   = d;
      @(posedge clk);
      #2;
      mem_mem_ena = 1'b0;
      mem_wr_ena  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic wait_init(input int start, input string name);
      int n;
      bit seen;
      n    = start;
      seen = 1'b0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         if (init_w[0]) seen = 1'b1;
         else begin
            idle(1);
            n++;
         end
      end
      check32(name, seen ? n : -1, DEPTH);
   endtask

   initial begin : stim
      int          got_n;
      int          first_c;
      int          last_c;
      logic [15:0] got_v [4];
      logic [15:0] a;
      int          r;

      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < NL; i++) begin
         check16("reset_rdata", rdata_w[i], 16'h0);
         check16("reset_hex", hex_w[i], 16'h0);
         check16("reset_init_done", {15'b0, init_w[i]}, 16'h0);
      end
      reset = 1'b0;

      // Requests during INIT must be ignored.
      cyc(1'b1, 1'b1, 16'h0010, 16'hFFFF);
      cyc(1'b1, 1'b1, IO, 16'h5A5A);
      cyc(1'b1, 1'b0, 16'h0010, 16'h0);
      wait_init(3, "init_length");
      for (int i = 0; i < NL; i++) check16("init_hex_untouched", hex_w[i], 16'h0);

      // Write then read on the next edge.
      cyc(1'b1, 1'b1, 16'h0005, 16'hBEEF);
      cyc(1'b1, 1'b0, 16'h0005, 16'h0);
      idle(1);
      check16("wr_rd_L1_data", rdata_w[0], 16'hBEEF);
      check16("wr_rd_L1_valid", {15'b0, rdv_w[0]}, 16'h1);
      idle(1);
      check16("wr_rd_L2_data", rdata_w[1], 16'hBEEF);
      check16("wr_rd_L2_valid", {15'b0, rdv_w[1]}, 16'h1);
      check16("wr_rd_L1_valid_once", {15'b0, rdv_w[0]}, 16'h0);
      check16("wr_rd_L4_not_yet", rdata_w[2], 16'h0);
      idle(2);
      check16("wr_rd_L4_data", rdata_w[2], 16'hBEEF);
      check16("wr_rd_L4_valid", {15'b0, rdv_w[2]}, 16'h1);
      idle(1);
      check16("wr_rd_L2_valid_once", {15'b0, rdv_w[1]}, 16'h0);

      cyc(1'b1, 1'b0, 16'h0010, 16'h0);
      idle(4);
      for (int i = 0; i < NL; i++) check16("init_write_dropped", rdata_w[i], 16'h0);

      // Switches are sampled on the request edge; hex loads on the write edge.
      sw_i = 16'h1234;
      cyc(1'b1, 1'b0, IO, 16'h0);
      sw_i = 16'h7777;
      idle(4);
      for (int i = 0; i < NL; i++) check16("io_read", rdata_w[i], 16'h1234);
      cyc(1'b1, 1'b1, IO, 16'h00A5);
      for (int i = 0; i < NL; i++) check16("io_write_hex", hex_w[i], 16'h00A5);
      cyc(1'b1, 1'b0, 16'h03FF, 16'h0);
      idle(4);
      for (int i = 0; i < NL; i++) check16("io_write_ram_alias", rdata_w[i], 16'h0);

      // Back-to-back burst.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 16'(i), 16'(i + 1));
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'(i), 16'h0);
      got_n   = 0;
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 6; c++) begin
         idle(1);
         if (rdv_w[2]) begin
            if (got_n < 4) got_v[got_n] = rdata_w[2];
            if (first_c < 0) first_c = c;
            last_c = c;
            got_n++;
         end
      end
      check32("burst_count", got_n, 4);
      check32("burst_span", last_c - first_c, 3);
      for (int i = 0; i < 4; i++) begin
         if (i < got_n) check16($sformatf("burst_val%0d", i), got_v[i], 16'(i + 1));
      end
      cyc(1'b1, 1'b0, 16'h0400, 16'h0);
      idle(4);
      for (int i = 0; i < NL; i++) check16("oob_read", rdata_w[i], 16'h0);

      // Randomised traffic, checked every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         r = $urandom_range(0, 5);
         case (r)
            0:       a = 16'($urandom_range(0, 15));
            1:       a = 16'h03F0 | 16'($urandom_range(0, 15));
            2:       a = 16'h0400 + 16'($urandom_range(0, 15));
            3:       a = IO;
            4:       a = 16'($urandom);
            default: a = 16'hFC05;
         endcase
         sw_i = 16'($urandom);
         cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 2), a, 16'($urandom));
      end
      idle(6);

      // Reset with reads in flight.
      cyc(1'b1, 1'b1, 16'h0000, 16'h1111);
      cyc(1'b1, 1'b1, 16'h0001, 16'h2222);
      idle(6);
      cyc(1'b1, 1'b0, 16'h0000, 16'h0);
      cyc(1'b1, 1'b0, 16'h0001, 16'h0);
      reset = 1'b1;
      #1;
      for (int i = 0; i < NL; i++) begin
         check16("async_rst_rdata", rdata_w[i], 16'h0);
         check16("async_rst_valid", {15'b0, rdv_w[i]}, 16'h0);
         check16("async_rst_hex", hex_w[i], 16'h0);
         check16("async_rst_init", {15'b0, init_w[i]}, 16'h0);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         for (int k = 0; k < NL; k++) check16("flushed_no_valid", {15'b0, rdv_w[k]}, 16'h0);
      end
      wait_init(6, "reinit_length");
      cyc(1'b1, 1'b0, 16'h0001, 16'h0);
      idle(5);
      for (int i = 0; i < NL; i++) check16("refilled_zero", rdata_w[i], 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
